// File: rtl/act_out_ni_reader.sv
// Streams activations 0..act_num-1 from the activation RF to the NI, one packet per activation.
// Reads are retried until the read mux grants them; a small registered FIFO absorbs NI backpressure.
module act_out_ni_reader #(
    parameter int ADDR_W     = 4,
    parameter int ACT_W      = 16,
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   act_num,
    output logic              busy,
    output logic              done,
    input  logic              comp_en_add,
    output logic              ni_read_rqst,
    output logic [ADDR_W-1:0] ni_read_addr,
    input  logic [ACT_W-1:0]  out_act_rdata,
    output logic              pkt_valid,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [ACT_W-1:0]  pkt_data,
    input  logic              pkt_ready
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing reads and draining packets
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t state, state_nxt;

    logic [ADDR_W:0]          act_num_q;
    logic [ADDR_W:0]          issued;
    logic                     inflight;
    logic [ADDR_W-1:0]        inflight_addr;
    logic [ADDR_W+ACT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         occ;

    logic empty, full, push, pop, grant, can_issue, run_done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue only depends on registers so the combinational read mux cannot form a loop.
    always_comb begin
        empty     = (occ == '0);
        full      = (occ == CNT_W'(FIFO_DEPTH));
        can_issue = (state == RUN) && (issued < act_num_q) &&
                    (({1'b0, occ} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH));
        grant     = can_issue && !comp_en_add;
        push      = inflight;
        pop       = !empty && pkt_ready;
        run_done  = (issued == act_num_q) && !inflight && empty;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (run_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == RUN);
        done         = (state == DONE);
        ni_read_rqst = can_issue;
        ni_read_addr = can_issue ? issued[ADDR_W-1:0] : '0;
        pkt_valid    = !empty;
        {pkt_addr, pkt_data} = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            act_num_q     <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= grant;
            if (state == IDLE && start) begin
                act_num_q <= act_num;
                issued    <= '0;
            end else if (grant) begin
                issued        <= issued + (ADDR_W+1)'(1);
                inflight_addr <= issued[ADDR_W-1:0];
            end
            if (push) begin
                mem[wr_ptr] <= {inflight_addr, out_act_rdata};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_act_out_ni_reader.sv
// Self-checking bench for act_out_ni_reader: directed timing scenarios plus randomized
// stall/backpressure runs compared against an in-order packet list built from an RF image.
module tb_act_out_ni_reader;
    localparam int ADDR_W = 4;
    localparam int ACT_W  = 16;
    localparam int MAXC   = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   act_num = '0;
    logic              busy, done;
    logic              comp_en_add = 1'b0;
    logic              ni_read_rqst;
    logic [ADDR_W-1:0] ni_read_addr;
    logic [ACT_W-1:0]  out_act_rdata = '0;
    logic              pkt_valid;
    logic [ADDR_W-1:0] pkt_addr;
    logic [ACT_W-1:0]  pkt_data;
    logic              pkt_ready = 1'b0;

    act_out_ni_reader #(.ADDR_W(ADDR_W), .ACT_W(ACT_W), .FIFO_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .start(start), .act_num(act_num), .busy(busy), .done(done),
        .comp_en_add(comp_en_add), .ni_read_rqst(ni_read_rqst), .ni_read_addr(ni_read_addr),
        .out_act_rdata(out_act_rdata), .pkt_valid(pkt_valid), .pkt_addr(pkt_addr),
        .pkt_data(pkt_data), .pkt_ready(pkt_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; int cyc; } pkt_t;

    int errors = 0;
    int checks = 0;

    logic [ACT_W-1:0] rf [16];
    bit   obs_rqst  [MAXC];
    int   obs_raddr [MAXC];
    bit   obs_valid [MAXC];
    int   obs_paddr [MAXC];
    int   obs_pdata [MAXC];
    bit   obs_busy  [MAXC];
    bit   obs_done  [MAXC];
    pkt_t pkts[$];
    int   done_cyc, done_cnt;

    // Drives one job starting at edge 0 and records what the DUT shows in cycles 1..ncyc-1.
    // The RF is modelled as a registered read: granted address -> data in the next cycle.
    task automatic run_job(input int n, input int ncyc, input int stall_lo, input int stall_hi,
                           input int ready_cyc, input int restart_cyc, input int rst_cyc,
                           input bit rnd);
        logic [ACT_W-1:0] nxt;
        bit gnt;
        nxt = '0;
        pkts.delete();
        done_cyc = -1;
        done_cnt = 0;
        act_num = (ADDR_W+1)'(n);
        start = 1'b1;
        comp_en_add = 1'b0;
        pkt_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < ncyc; c++) begin
            comp_en_add = rnd ? ($urandom_range(0, 2) == 0) : (c >= stall_lo && c <= stall_hi);
            pkt_ready   = rnd ? ($urandom_range(0, 3) != 0) : (c >= ready_cyc);
            start       = (c == restart_cyc);
            if (c == restart_cyc) act_num = 5'd9;
            rst         = (c == rst_cyc);
            @(negedge clk);
            obs_rqst[c]  = ni_read_rqst;
            obs_raddr[c] = int'(ni_read_addr);
            obs_valid[c] = pkt_valid;
            obs_paddr[c] = int'(pkt_addr);
            obs_pdata[c] = int'(pkt_data);
            obs_busy[c]  = busy;
            obs_done[c]  = done;
            gnt = ni_read_rqst && !comp_en_add;
            if (gnt) nxt = rf[ni_read_addr];
            if (pkt_valid && pkt_ready) pkts.push_back('{int'(pkt_addr), int'(pkt_data), c});
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
            if (gnt) out_act_rdata = nxt;
        end
        comp_en_add = 1'b0;
        pkt_ready = 1'b0;
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic fill_rf_random();
        for (int i = 0; i < 16; i++) rf[i] = ACT_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, ni_read_rqst, pkt_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/rqst/valid=%b want 0000", {busy, done, ni_read_rqst, pkt_valid});
        end
        checks++;
        if ({ni_read_addr, pkt_addr, pkt_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: got raddr=%0d paddr=%0d pdata=%0d want 0", ni_read_addr, pkt_addr, pkt_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) rf[i] = ACT_W'(i * 3);
        run_job(4, 12, 0, -1, 0, 0, 0, 1'b0);
        for (int c = 1; c < 11; c++) begin
            checks++;
            if (obs_rqst[c] !== (c <= 4) || (c <= 4 && obs_raddr[c] != c - 1)) begin
                errors++;
                $display("FAIL basic_rqst c%0d: got rqst=%0b addr=%0d want rqst=%0b addr=%0d", c, obs_rqst[c], obs_raddr[c], c <= 4, c - 1);
            end
        end
        checks++;
        if (pkts.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d packets want 4", pkts.size());
        end
        for (int i = 0; i < pkts.size() && i < 4; i++) begin
            checks++;
            if (pkts[i].addr != i || pkts[i].data != 3 * i || pkts[i].cyc != 3 + i) begin
                errors++;
                $display("FAIL basic_pkt%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, pkts[i].addr, pkts[i].data, pkts[i].cyc, i, 3 * i, 3 + i);
            end
        end
        checks++;
        if (done_cyc != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done: got cycle %0d count %0d want cycle 8 count 1", done_cyc, done_cnt);
        end
        for (int c = 1; c < 10; c++) begin
            checks++;
            if (obs_busy[c] !== (c <= 7)) begin
                errors++;
                $display("FAIL basic_busy c%0d: got %0b want %0b", c, obs_busy[c], c <= 7);
            end
        end
    endtask

    task automatic test_comp_stall();
        for (int i = 0; i < 16; i++) rf[i] = ACT_W'(i * 3);
        run_job(4, 15, 2, 4, 0, 0, 0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if (!obs_rqst[c] || obs_raddr[c] != 1) begin
                errors++;
                $display("FAIL stall_hold c%0d: got rqst=%0b addr=%0d want rqst=1 addr=1", c, obs_rqst[c], obs_raddr[c]);
            end
        end
        checks++;
        if (pkts.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d packets want 4", pkts.size());
        end
        for (int i = 0; i < pkts.size() && i < 4; i++) begin
            checks++;
            if (pkts[i].addr != i || pkts[i].data != 3 * i || pkts[i].cyc != (i == 0 ? 3 : 6 + i)) begin
                errors++;
                $display("FAIL stall_pkt%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i, pkts[i].addr, pkts[i].data, pkts[i].cyc, i, 3 * i, i == 0 ? 3 : 6 + i);
            end
        end
        checks++;
        if (done_cyc != 11 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: got cycle %0d count %0d want cycle 11 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int grants;
        fill_rf_random();
        run_job(8, 40, 0, -1, 10, 0, 0, 1'b0);
        grants = 0;
        for (int c = 1; c < 10; c++) if (obs_rqst[c]) grants++;
        checks++;
        if (grants != 3) begin
            errors++;
            $display("FAIL bp_grants: got %0d grants before release want 3", grants);
        end
        for (int c = 3; c < 10; c++) begin
            checks++;
            if (!obs_valid[c] || obs_paddr[c] != 0 || obs_pdata[c] != int'(rf[0])) begin
                errors++;
                $display("FAIL bp_hold c%0d: got valid=%0b (%0d,%0d) want valid=1 (0,%0d)", c, obs_valid[c], obs_paddr[c], obs_pdata[c], rf[0]);
            end
        end
        checks++;
        if (pkts.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_count: got %0d packets %0d dones want 8 packets 1 done", pkts.size(), done_cnt);
        end
        for (int i = 0; i < pkts.size() && i < 8; i++) begin
            checks++;
            if (pkts[i].addr != i || pkts[i].data != int'(rf[i])) begin
                errors++;
                $display("FAIL bp_pkt%0d: got (%0d,%0d) want (%0d,%0d)", i, pkts[i].addr, pkts[i].data, i, rf[i]);
            end
        end
    endtask

    task automatic test_zero();
        int rq, vl, bz;
        run_job(0, 8, 0, -1, 0, 0, 0, 1'b0);
        rq = 0; vl = 0; bz = 0;
        for (int c = 1; c < 8; c++) begin
            if (obs_rqst[c]) rq++;
            if (obs_valid[c]) vl++;
            if (obs_busy[c]) bz++;
        end
        checks++;
        if (rq != 0 || vl != 0) begin
            errors++;
            $display("FAIL zero_activity: got %0d rqst cycles %0d valid cycles want 0 0", rq, vl);
        end
        checks++;
        if (bz != 1 || !obs_busy[1]) begin
            errors++;
            $display("FAIL zero_busy: got %0d busy cycles want 1 (cycle 1)", bz);
        end
        checks++;
        if (done_cyc != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done: got cycle %0d count %0d want cycle 2 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        fill_rf_random();
        run_job(5, 20, 0, -1, 0, 3, 0, 1'b0);
        checks++;
        if (pkts.size() != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_count: got %0d packets %0d dones want 5 packets 1 done", pkts.size(), done_cnt);
        end
        for (int i = 0; i < pkts.size() && i < 5; i++) begin
            checks++;
            if (pkts[i].addr != i || pkts[i].data != int'(rf[i])) begin
                errors++;
                $display("FAIL restart_pkt%0d: got (%0d,%0d) want (%0d,%0d)", i, pkts[i].addr, pkts[i].data, i, rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_rf_random();
        run_job(6, 14, 0, -1, 0, 0, 4, 1'b0);
        checks++;
        if ({obs_rqst[5], obs_valid[5], obs_busy[5], obs_done[5]} !== 4'b0 ||
            obs_raddr[5] != 0 || obs_paddr[5] != 0 || obs_pdata[5] != 0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rqst=%0b valid=%0b busy=%0b done=%0b raddr=%0d paddr=%0d pdata=%0d want all 0",
                     obs_rqst[5], obs_valid[5], obs_busy[5], obs_done[5], obs_raddr[5], obs_paddr[5], obs_pdata[5]);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_done: got %0d done pulses want 0", done_cnt);
        end
        run_job(2, 12, 0, -1, 0, 0, 0, 1'b0);
        checks++;
        if (pkts.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_restart_count: got %0d packets %0d dones want 2 packets 1 done", pkts.size(), done_cnt);
        end
        for (int i = 0; i < pkts.size() && i < 2; i++) begin
            checks++;
            if (pkts[i].addr != i || pkts[i].data != int'(rf[i])) begin
                errors++;
                $display("FAIL rstmid_pkt%0d: got (%0d,%0d) want (%0d,%0d)", i, pkts[i].addr, pkts[i].data, i, rf[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 10; it++) begin
            fill_rf_random();
            n = $urandom_range(0, 16);
            run_job(n, 150, 0, -1, 0, 0, 0, 1'b1);
            checks++;
            if (pkts.size() != n || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d packets %0d dones want %0d packets 1 done", it, pkts.size(), done_cnt, n);
            end
            for (int i = 0; i < pkts.size() && i < n; i++) begin
                checks++;
                if (pkts[i].addr != i || pkts[i].data != int'(rf[i])) begin
                    errors++;
                    $display("FAIL rand%0d_pkt%0d: got (%0d,%0d) want (%0d,%0d)", it, i, pkts[i].addr, pkts[i].data, i, rf[i]);
                end
            end
            if (n > 0 && pkts.size() > 0) begin
                checks++;
                if (done_cyc <= pkts[pkts.size() - 1].cyc) begin
                    errors++;
                    $display("FAIL rand%0d_done_order: got done@%0d want after last packet@%0d", it, done_cyc, pkts[pkts.size() - 1].cyc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_comp_stall();
        test_backpressure();
        test_zero();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
